arashi_mem_rr: RTL and testbench

//  Shared cache->thread return buffer: single-writer FIFO drained by an internal round-robin

---
 rtl/arashi_mem_rr.sv | 120 ++++++++++++
 tb/tb_arashi_mem_rr.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arashi_mem_rr.sv
// Cache-to-thread return buffer: single-writer FIFO drained by a round-robin arbiter over THREAD_NUM readers.
// Optional feature macro: ARASHI_MEM_BYPASS_EN (empty-FIFO write goes straight to the output register).
module arashi_mem_rr #(
    parameter int DATA_WIDTH = 32,
    parameter int THREAD_NUM = 4,
    parameter int MEM_WIDTH  = 4,
    parameter int AFULL_LVL  = 12
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             wr_valid,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             wr_ready,
    input  logic [THREAD_NUM-1:0]            r_ena,
    output logic [THREAD_NUM-1:0]            r_ready,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] data_out,
    output logic [MEM_WIDTH:0]               count,
    output logic                             empty,
    output logic                             full,
    output logic                             almost_full
);

    localparam int DEPTH = 1 << MEM_WIDTH;
    localparam int TW    = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;
    localparam logic [MEM_WIDTH:0]   DEPTH_C = (MEM_WIDTH+1)'(DEPTH);
    localparam logic [MEM_WIDTH:0]   AFULL_C = (MEM_WIDTH+1)'(AFULL_LVL);
    localparam logic [MEM_WIDTH:0]   CNT_ONE = (MEM_WIDTH+1)'(1);
    localparam logic [MEM_WIDTH-1:0] PTR_ONE = MEM_WIDTH'(1);

    logic [DATA_WIDTH-1:0]            mem_q [DEPTH];
    logic [MEM_WIDTH-1:0]             wptr_q, wptr_d;
    logic [MEM_WIDTH-1:0]             rptr_q, rptr_d;
    logic [MEM_WIDTH:0]               count_q, count_d;
    logic [TW-1:0]                    rr_last_q, rr_last_d;
    logic [THREAD_NUM-1:0]            r_ready_q, r_ready_d;
    logic [DATA_WIDTH*THREAD_NUM-1:0] data_out_q, data_out_d;

    logic                  push, push_store, pop, grant, grant_any, bypass;
    logic [TW-1:0]         winner, scan_idx;
    logic [DATA_WIDTH-1:0] pop_word;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);
    assign wr_ready    = !full;
    assign count       = count_q;
    assign r_ready     = r_ready_q;
    assign data_out    = data_out_q;

    assign push = wr_valid & wr_ready;

`ifdef ARASHI_MEM_BYPASS_EN
    assign bypass = empty & push & (|r_ena);
`else
    assign bypass = 1'b0;
`endif

    // First requester after the last winner, wrapping modulo THREAD_NUM.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int k = 1; k <= THREAD_NUM; k++) begin
            scan_idx = TW'((int'(rr_last_q) + k) % THREAD_NUM);
            if (!grant_any && r_ena[scan_idx]) begin
                grant_any = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign grant      = grant_any & (!empty | bypass);
    assign pop        = grant & !bypass;
    assign push_store = push & !bypass;
    assign pop_word   = bypass ? wr_data : mem_q[rptr_q];

    always_comb begin
        wptr_d     = push_store ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_ONE : rptr_q;
        count_d    = count_q;
        rr_last_d  = grant ? winner : rr_last_q;
        r_ready_d  = '0;
        data_out_d = '0;
        case ({push_store, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (grant) begin
            r_ready_d[winner] = 1'b1;
            data_out_d[int'(winner)*DATA_WIDTH +: DATA_WIDTH] = pop_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rr_last_q  <= TW'(THREAD_NUM - 1);
            r_ready_q  <= '0;
            data_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rr_last_q  <= rr_last_d;
            r_ready_q  <= r_ready_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is intentionally not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_arashi_mem_rr.sv
// Bench for arashi_mem_rr: directed tables, hand-written corner sequences and random traffic against a queue model.
module tb_arashi_mem_rr;

    localparam int DW    = 32;
    localparam int TN    = 4;
    localparam int MW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
`ifdef ARASHI_MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            wr_valid = 1'b0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_ready;
    logic [TN-1:0]   r_ena = '0;
    logic [TN-1:0]   r_ready;
    logic [DW*TN-1:0] data_out;
    logic [MW:0]     count;
    logic            empty, full, almost_full;

    logic            wr_valid3 = 1'b0;
    logic [DW-1:0]   wr_data3 = '0;
    logic            wr_ready3;
    logic [2:0]      r_ena3 = '0;
    logic [2:0]      r_ready3;
    logic [DW*3-1:0] data_out3;
    logic [MW:0]     count3;
    logic            empty3, full3, almost_full3;

    always #5 clk = ~clk;

    arashi_mem_rr #(.DATA_WIDTH(DW), .THREAD_NUM(TN), .MEM_WIDTH(MW), .AFULL_LVL(AF)) u_dut (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .r_ena(r_ena), .r_ready(r_ready), .data_out(data_out), .count(count),
        .empty(empty), .full(full), .almost_full(almost_full));

    arashi_mem_rr #(.DATA_WIDTH(DW), .THREAD_NUM(3), .MEM_WIDTH(MW), .AFULL_LVL(AF)) u_dut3 (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid3), .wr_data(wr_data3), .wr_ready(wr_ready3),
        .r_ena(r_ena3), .r_ready(r_ready3), .data_out(data_out3), .count(count3),
        .empty(empty3), .full(full3), .almost_full(almost_full3));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a plain queue of stored words plus the last winning thread.
    logic [DW-1:0]    mq[$];
    int               m_rr;
    logic [TN-1:0]    m_rready;
    logic [DW*TN-1:0] m_dout;

    task automatic model_reset();
        mq.delete();
        m_rr     = TN - 1;
        m_rready = '0;
        m_dout   = '0;
    endtask

    task automatic model_step(input bit wv, input logic [DW-1:0] wd, input logic [TN-1:0] re);
        int cnt;
        bit push, byp;
        int win;
        logic [DW-1:0] word;
        cnt  = mq.size();
        push = wv && (cnt < DEPTH);
        byp  = BYP && (cnt == 0) && push && (re != 0);
        win  = -1;
        if (re != 0 && (cnt > 0 || byp)) begin
            for (int k = 1; k <= TN; k++) begin
                if (win < 0 && re[(m_rr + k) % TN]) win = (m_rr + k) % TN;
            end
        end
        m_rready = '0;
        m_dout   = '0;
        if (win >= 0) begin
            word = byp ? wd : mq.pop_front();
            m_rready[win] = 1'b1;
            m_dout[win*DW +: DW] = word;
            m_rr = win;
        end
        if (push && !byp) mq.push_back(wd);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"},    count,       mq.size());
        chk({tag, "_empty"},    empty,       mq.size() == 0);
        chk({tag, "_full"},     full,        mq.size() == DEPTH);
        chk({tag, "_afull"},    almost_full, mq.size() >= AF);
        chk({tag, "_wr_ready"}, wr_ready,    mq.size() < DEPTH);
        chk({tag, "_r_ready"},  r_ready,     m_rready);
        chk({tag, "_data_out"}, data_out,    m_dout);
    endtask

    // Checks current outputs against the model, drives new inputs, advances one clock.
    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input logic [TN-1:0] re, input string tag);
        @(negedge clk);
        check_all(tag);
        wr_valid = wv;
        wr_data  = wd;
        r_ena    = re;
        model_step(wv, wd, re);
        @(posedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0;
        wr_valid = 1'b0; r_ena = '0; wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        bit            wv;
        logic [DW-1:0] wd;
        logic [TN-1:0] re;
        int            exp_count;
        bit            exp_full;
        bit            exp_afull;
        bit            exp_wr_ready;
        logic [TN-1:0] exp_rready;
        logic [DW-1:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vecs(input int first, input int last, input string tag);
        logic [DW*TN-1:0] e;
        for (int i = first; i <= last; i++) begin
            cycle(vecs[i].wv, vecs[i].wd, vecs[i].re, tag);
            #1;
            e = '0;
            for (int t = 0; t < TN; t++) if (vecs[i].exp_rready[t]) e[t*DW +: DW] = vecs[i].exp_word;
            chk({tag, "_tbl_count"},  count,       vecs[i].exp_count);
            chk({tag, "_tbl_full"},   full,        vecs[i].exp_full);
            chk({tag, "_tbl_afull"},  almost_full, vecs[i].exp_afull);
            chk({tag, "_tbl_wrrdy"},  wr_ready,    vecs[i].exp_wr_ready);
            chk({tag, "_tbl_rready"}, r_ready,     vecs[i].exp_rready);
            chk({tag, "_tbl_data"},   data_out,    e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW*3-1:0] e3;
        logic [DW*TN-1:0] e;
        vec_t v;

        // Fill: 17 pushes into a 16-deep buffer, no readers.
        for (int i = 0; i < 17; i++) begin
            v.wv = 1'b1; v.wd = 32'h100 + i; v.re = '0;
            v.exp_count = (i + 1 > 16) ? 16 : i + 1;
            v.exp_full = (v.exp_count == 16); v.exp_afull = (v.exp_count >= 12);
            v.exp_wr_ready = !v.exp_full; v.exp_rready = '0; v.exp_word = '0;
            vecs.push_back(v);
        end
        // Round robin over all four threads, FIFO holding 0xA0..0xA7.
        for (int i = 0; i < 8; i++) begin
            v.wv = 1'b0; v.wd = '0; v.re = 4'b1111;
            v.exp_count = 7 - i; v.exp_full = 1'b0; v.exp_afull = 1'b0; v.exp_wr_ready = 1'b1;
            v.exp_rready = 4'(1 << (i % 4)); v.exp_word = 32'hA0 + i;
            vecs.push_back(v);
        end

        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        apply_vecs(0, 16, "fill");

        // Full with a simultaneous grant: no push; the next push lands.
        cycle(1'b1, 32'h1F0, 4'b0001, "fullpop");
        #1;
        chk("fullpop_count", count, 15);
        chk("fullpop_wr_ready", wr_ready, 1'b1);
        chk("fullpop_lane0", data_out, {96'h0, 32'h100});
        cycle(1'b1, 32'h1F1, 4'b0000, "refill");
        #1;
        chk("refill_count", count, 16);
        chk("refill_full", full, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b0, '0, 4'b1111, "drain");
        cycle(1'b0, '0, '0, "drain_idle");

        reset_dut();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA0 + i, '0, "rrfill");
        apply_vecs(17, 24, "rr");
        cycle(1'b0, '0, '0, "rr_idle");

        // Empty buffer, write coincides with a thread-2 request.
        cycle(1'b1, 32'h55, 4'b0100, "byp1");
        #1;
        e = '0; e[2*DW +: DW] = 32'h55;
        chk("byp1_rready", r_ready, BYP ? 4'b0100 : 4'b0000);
        chk("byp1_data", data_out, BYP ? e : '0);
        chk("byp1_count", count, BYP ? 0 : 1);
        cycle(1'b0, '0, 4'b0100, "byp2");
        #1;
        chk("byp2_rready", r_ready, BYP ? 4'b0000 : 4'b0100);
        chk("byp2_data", data_out, BYP ? '0 : e);
        chk("byp2_count", count, 0);
        cycle(1'b0, '0, '0, "byp_idle");

        for (int i = 0; i < 400; i++) begin
            bit wv;
            logic [TN-1:0] re;
            wv = (i < 200) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 30);
            re = ($urandom_range(0, 99) < 40) ? 4'b0000 : 4'($urandom_range(0, 15));
            cycle(wv, $urandom, re, "rand");
        end
        cycle(1'b0, '0, '0, "rand_idle");

        // Asynchronous reset in the middle of traffic.
        reset_dut();
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'hD0 + i, '0, "pre_rst");
        cycle(1'b0, '0, 4'b0001, "pre_rst_pop");
        #2;
        rstn = 1'b0;
        wr_valid = 1'b0; r_ena = '0;
        model_reset();
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1'b1);
        chk("async_rready", r_ready, 4'b0000);
        chk("async_data", data_out, '0);
        chk("async_wr_ready", wr_ready, 1'b1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, '0, '0, "post_rst_idle");
        cycle(1'b1, 32'h77, '0, "post_rst_push");
        cycle(1'b0, '0, 4'b1111, "post_rst_grant");
        #1;
        chk("post_rst_rready", r_ready, 4'b0001);
        chk("post_rst_data", data_out, {96'h0, 32'h77});
        cycle(1'b0, '0, '0, "post_rst_end");

        // Three-thread instance: threads 0 and 2 requesting alternate.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid3 = 1'b1; wr_data3 = 32'hC0 + i; r_ena3 = 3'b000;
            @(posedge clk);
        end
        #1;
        chk("t3_count", count3, 6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid3 = 1'b0; r_ena3 = 3'b101;
            @(posedge clk);
            #1;
            e3 = '0;
            e3[((i % 2) ? 2 : 0)*DW +: DW] = 32'hC0 + i;
            chk("t3_rready", r_ready3, (i % 2) ? 3'b100 : 3'b001);
            chk("t3_data", data_out3, e3);
        end
        #1;
        chk("t3_empty", empty3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
